// File: rtl/corr_acq_tracker_pkg.sv
//==========================================================================
// corr_pkg: shared acquisition-state encoding and correlator width. Rev 1.0
//==========================================================================
`default_nettype none

package corr_pkg;

   localparam int CORR_W_DEF = 32;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } acq_state_t;

endpackage

`default_nettype wire

// File: rtl/corr_acq_tracker_if.sv
//==========================================================================
// corr_acq_tracker_if: correlator-to-tracker bus with master/slave views. Rev 1.0
//==========================================================================
`default_nettype none

interface corr_acq_tracker_if import corr_pkg::*; #(
   parameter int CORR_W = CORR_W_DEF
);

   logic              sync;
   logic              dump;
   logic [CORR_W-1:0] corr;
   logic [CORR_W-2:0] thresh;
   logic              slip;
   logic              locked;
   logic              bit_valid;
   logic              bit_out;
   logic [CORR_W-2:0] mag_out;
   logic [1:0]        state_dbg;

   modport master (
      output sync, dump, corr, thresh,
      input  slip, locked, bit_valid, bit_out, mag_out, state_dbg
   );

   modport slave (
      input  sync, dump, corr, thresh,
      output slip, locked, bit_valid, bit_out, mag_out, state_dbg
   );

endinterface

`default_nettype wire

// File: rtl/corr_acq_tracker_abs_sat.sv
//==========================================================================
// corr_abs_sat: combinational |x| with the most negative value clamped. Rev 1.0
//==========================================================================
`default_nettype none

module corr_abs_sat #(
   parameter int W = 32
) (
   input  logic [W-1:0] x_i,
   output logic [W-2:0] mag_o
);

   localparam int NW = W - 1;

   logic [W-2:0] w_neg;

   always_comb begin
      w_neg = ~x_i[W-2:0] + NW'(1);
      if (!x_i[W-1]) begin
         mag_o = x_i[W-2:0];
      end else if (x_i[W-2:0] == '0) begin
         // -2^(W-1) has no positive twin; clamp to the largest magnitude
         mag_o = '1;
      end else begin
         mag_o = w_neg;
      end
   end

endmodule

`default_nettype wire

// File: rtl/corr_acq_tracker.sv
//==========================================================================
// corr_acq_tracker: dump-driven SEARCH/VERIFY/LOCK acquisition and bit despreading. Rev 1.0
//==========================================================================
`default_nettype none

module corr_acq_tracker import corr_pkg::*; #(
   parameter int CORR_W    = CORR_W_DEF,
   parameter int VERIFY_N  = 3,
   parameter int MISS_N    = 4,
   parameter int DISCARD_N = 1
) (
   input  logic              clk,
   input  logic              reset,
   corr_acq_tracker_if.slave bus
);

   localparam int HIT_W  = $clog2(VERIFY_N) + 1;
   localparam int MISS_W = $clog2(MISS_N) + 1;
   localparam int DISC_W = $clog2(DISCARD_N) + 1;

   localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(VERIFY_N - 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_N - 1);
   localparam logic [DISC_W-1:0] DISC_LOAD = DISC_W'(DISCARD_N);

   logic [CORR_W-2:0] w_mag;
   logic              w_hit;

   acq_state_t        state_q;
   logic [HIT_W-1:0]  hit_cnt_q;
   logic [MISS_W-1:0] miss_cnt_q;
   logic [DISC_W-1:0] disc_cnt_q;
   logic              slip_q;
   logic              locked_q;
   logic              bit_valid_q;
   logic              bit_out_q;
   logic [CORR_W-2:0] mag_q;

   corr_abs_sat #(
      .W (CORR_W)
   ) u_abs_sat (
      .x_i   (bus.corr),
      .mag_o (w_mag)
   );

   assign w_hit = (w_mag > bus.thresh);

   always_ff @(posedge clk) begin
      slip_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      if (reset) begin
         state_q    <= SEARCH;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         disc_cnt_q <= '0;
         locked_q   <= 1'b0;
         bit_out_q  <= 1'b0;
         mag_q      <= '0;
      end else if (bus.sync) begin
         state_q    <= SEARCH;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         disc_cnt_q <= '0;
         locked_q   <= 1'b0;
      end else if (bus.dump) begin
         if (disc_cnt_q != '0) begin
            // period straddled a code-phase slip; its sum is meaningless
            disc_cnt_q <= disc_cnt_q - DISC_W'(1);
         end else begin
            mag_q <= w_mag;
            case (state_q)
               SEARCH: begin
                  if (w_hit) begin
                     if (VERIFY_N == 1) begin
                        state_q    <= LOCK;
                        locked_q   <= 1'b1;
                        miss_cnt_q <= '0;
                     end else begin
                        state_q   <= VERIFY;
                        hit_cnt_q <= HIT_W'(1);
                     end
                  end else begin
                     slip_q     <= 1'b1;
                     disc_cnt_q <= DISC_LOAD;
                  end
               end
               VERIFY: begin
                  if (w_hit) begin
                     if (hit_cnt_q == HIT_LAST) begin
                        state_q    <= LOCK;
                        locked_q   <= 1'b1;
                        miss_cnt_q <= '0;
                        hit_cnt_q  <= '0;
                     end else begin
                        hit_cnt_q <= hit_cnt_q + HIT_W'(1);
                     end
                  end else begin
                     state_q    <= SEARCH;
                     hit_cnt_q  <= '0;
                     slip_q     <= 1'b1;
                     disc_cnt_q <= DISC_LOAD;
                  end
               end
               LOCK: begin
                  bit_valid_q <= 1'b1;
                  bit_out_q   <= ~bus.corr[CORR_W-1];
                  if (w_hit) begin
                     miss_cnt_q <= '0;
                  end else if (miss_cnt_q == MISS_LAST) begin
                     // losing lock keeps the current phase: no slip here
                     state_q    <= SEARCH;
                     locked_q   <= 1'b0;
                     miss_cnt_q <= '0;
                  end else begin
                     miss_cnt_q <= miss_cnt_q + MISS_W'(1);
                  end
               end
               default: begin
                  state_q  <= SEARCH;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.slip      = slip_q;
   assign bus.locked    = locked_q;
   assign bus.bit_valid = bit_valid_q;
   assign bus.bit_out   = bit_out_q;
   assign bus.mag_out   = mag_q;
   assign bus.state_dbg = state_q;

endmodule

`default_nettype wire

// File: tb/tb_corr_acq_tracker.sv
//==========================================================================
// tb_corr_acq_tracker: directed acquisition/lock/boundary sequence for corr_acq_tracker. Rev 1.0
//==========================================================================
`default_nettype none

module tb_corr_acq_tracker;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   corr_acq_tracker_if #(.CORR_W(32)) bus ();

   corr_acq_tracker #(
      .CORR_W    (32),
      .VERIFY_N  (3),
      .MISS_N    (4),
      .DISCARD_N (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic e_slip, input logic e_bv,
                             input logic e_bo, input logic e_lk, input logic [1:0] e_st,
                             input logic [30:0] e_mag);
      check({tag, ".slip"},      64'(bus.slip),      64'(e_slip));
      check({tag, ".bit_valid"}, 64'(bus.bit_valid), 64'(e_bv));
      check({tag, ".bit_out"},   64'(bus.bit_out),   64'(e_bo));
      check({tag, ".locked"},    64'(bus.locked),    64'(e_lk));
      check({tag, ".state"},     64'(bus.state_dbg), 64'(e_st));
      check({tag, ".mag_out"},   64'(bus.mag_out),   64'(e_mag));
   endtask

   // one-cycle dump; returns at the next falling edge with the result visible
   task automatic dump_step(input logic [31:0] v);
      @(negedge clk);
      bus.dump = 1'b1;
      bus.corr = v;
      @(negedge clk);
      bus.dump = 1'b0;
   endtask

   task automatic sync_dump_step(input logic [31:0] v);
      @(negedge clk);
      bus.sync = 1'b1;
      bus.dump = 1'b1;
      bus.corr = v;
      @(negedge clk);
      bus.sync = 1'b0;
      bus.dump = 1'b0;
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      bus.sync   = 1'b0;
      bus.dump   = 1'b0;
      bus.corr   = 32'd0;
      bus.thresh = 31'd1000;

      // reset and idle
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      expect_out("rst", 0, 0, 0, 0, 2'd0, 31'd0);
      repeat (3) @(negedge clk);
      expect_out("idle", 0, 0, 0, 0, 2'd0, 31'd0);

      // search with slip and discard
      dump_step(32'd200);
      expect_out("s1", 1, 0, 0, 0, 2'd0, 31'd200);
      dump_step(32'd200);
      expect_out("s2_disc", 0, 0, 0, 0, 2'd0, 31'd200);
      dump_step(32'd200);
      expect_out("s3", 1, 0, 0, 0, 2'd0, 31'd200);
      dump_step(32'd0);
      expect_out("s4_disc", 0, 0, 0, 0, 2'd0, 31'd200);

      // verify into lock
      dump_step(32'd1500);
      expect_out("v1", 0, 0, 0, 0, 2'd1, 31'd1500);
      dump_step(-32'sd1600);
      expect_out("v2", 0, 0, 0, 0, 2'd1, 31'd1600);
      dump_step(32'd1200);
      expect_out("v3", 0, 0, 0, 1, 2'd2, 31'd1200);
      dump_step(32'd1500);
      expect_out("l1", 0, 1, 1, 1, 2'd2, 31'd1500);

      // misses below MISS_N, then a hit resets the count
      for (int i = 0; i < 3; i++) begin
         dump_step(32'd500);
         expect_out($sformatf("m%0d", i), 0, 1, 1, 1, 2'd2, 31'd500);
      end
      dump_step(32'd2000);
      expect_out("rehit", 0, 1, 1, 1, 2'd2, 31'd2000);
      dump_step(32'd500);
      expect_out("d1", 0, 1, 1, 1, 2'd2, 31'd500);
      dump_step(-32'sd500);
      expect_out("d2", 0, 1, 0, 1, 2'd2, 31'd500);
      dump_step(32'd500);
      expect_out("d3", 0, 1, 1, 1, 2'd2, 31'd500);
      dump_step(-32'sd500);
      expect_out("d4_drop", 0, 1, 0, 0, 2'd0, 31'd500);

      // boundaries
      dump_step(32'd1000);
      expect_out("eq_thresh", 1, 0, 0, 0, 2'd0, 31'd1000);
      dump_step(32'd0);
      expect_out("b_disc", 0, 0, 0, 0, 2'd0, 31'd1000);
      dump_step(32'h8000_0000);
      expect_out("minneg", 0, 0, 0, 0, 2'd1, 31'h7FFF_FFFF);
      sync_dump_step(32'd0);
      expect_out("sync_v", 0, 0, 0, 0, 2'd0, 31'h7FFF_FFFF);

      // back-to-back dumps
      @(negedge clk);
      bus.dump = 1'b1;
      bus.corr = 32'd2000;
      @(negedge clk);
      expect_out("bb1", 0, 0, 0, 0, 2'd1, 31'd2000);
      @(negedge clk);
      expect_out("bb2", 0, 0, 0, 0, 2'd1, 31'd2000);
      @(negedge clk);
      bus.dump = 1'b0;
      expect_out("bb3", 0, 0, 0, 1, 2'd2, 31'd2000);

      sync_dump_step(32'd5000);
      expect_out("sync_l", 0, 0, 0, 0, 2'd0, 31'd2000);
      dump_step(32'd1001);
      expect_out("just_hit", 0, 0, 0, 0, 2'd1, 31'd1001);
      repeat (3) @(negedge clk);
      expect_out("idle2", 0, 0, 0, 0, 2'd1, 31'd1001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
